lsu_split: RTL and testbench
============================

Name: lsu_split

Overview:
- Parametrised load/store unit that sits between the EX stage of the pipelined core and the data-memory/cache port.
- Accepts one memory operation at a time over a valid/ready handshake and drives a byte-masked, bus-aligned data port with a ready handshake.
- Splits misaligned accesses that cross a bus word into two beats, rotates and sign- or zero-extends load data, and returns one response per request.
- Raises O_stall to the pipeline while busy.

Parameters:
- XLEN, 32, data width in bits; 32 or 64. NB = XLEN/8 byte lanes.
- ADDR_W, 32, byte-address width.
- MISALIGN_SPLIT, 1, 1 = split word-crossing accesses into two beats; 0 = report them as a fault without a bus access.

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_req_valid  in  1  request present.
- O_req_ready  out  1  unit can accept a request.
- I_req_we  in  1  1 = store, 0 = load.
- I_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when XLEN=64).
- I_req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- I_req_addr  in  ADDR_W  byte address.
- I_req_wdata  in  XLEN  store data, right-justified.
- I_req_rd  in  5  destination register tag, passed through to the response.
- O_rsp_valid  out  1  single-cycle response pulse.
- O_rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- O_rsp_rd  out  5  tag; 0 for stores.
- O_rsp_fault  out  1  illegal size or unsplit misalignment.
- O_dmem_addr  out  ADDR_W  bus address, NB-aligned.
- O_dmem_wdata  out  XLEN  lane-rotated store data.
- O_dmem_wmask  out  NB  byte enables.
- O_dmem_rd  out  1  read strobe.
- O_dmem_we  out  1  write strobe.
- I_dmem_ready  in  1  beat accepted; for reads, I_dmem_rdata is valid in the same cycle.
- I_dmem_rdata  in  XLEN  read data.
- O_stall  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, I_rst_n low): state = IDLE. All O_dmem_* = 0, O_rsp_* = 0, O_stall = 0. O_req_ready = 1 after reset deasserts.
- Reset mid-operation: the strobes drop in the same instant; the in-flight request is discarded and no response is issued.
- O_req_ready = (state == IDLE). A request is accepted on a clock edge where I_req_valid and O_req_ready are both high. All request fields are latched at acceptance.
- Derived values: off = addr mod NB; bytes = 1 << size; cross = (off + bytes > NB).
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE -> on accept:
  - to RESP with fault when the size is illegal, or when cross = 1 and MISALIGN_SPLIT = 0;
  - otherwise to BEAT0.
- BEAT0: O_dmem_addr = addr & ~(NB-1); wmask = ((1<<bytes)-1) << off, truncated to NB bits. The strobe (rd or we) is asserted from the first cycle after acceptance.
  - Address, data, mask and strobe are held stable until I_dmem_ready is high on an edge.
  - On that edge, capture rdata into lo; go to BEAT1 if cross, else RESP.
- BEAT1: addr = beat0 addr + NB; wmask = ((1<<bytes)-1) >> (NB-off). Same hold rule; capture rdata into hi; go to RESP.
- Store data: wdata = I_req_wdata << (8*off) for beat0; the overflowing bytes go to beat1 in lanes 0...
- Load data: ({hi,lo} >> 8*off), truncated to bytes, then extended per the latched signed flag. hi = 0 when there is no second beat.
- RESP: O_rsp_valid = 1 for exactly one cycle, then IDLE. Strobes are 0 in RESP.
  - Minimum latency, load with zero-wait bus: accept at T, beat at T+1, rsp_valid at T+2.
  - Fault: rsp_valid at T+1 with fault = 1, no bus strobe.
- No new request is accepted in RESP; back-to-back throughput is one request per 3 cycles minimum.
- Address arithmetic wraps modulo 2^ADDR_W (BEAT1 of the top word goes to address 0).
- O_dmem_rd and O_dmem_we are never high together.

Decomposition:
- Package lsu_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum;
  - a function bytes_of(size).
- Sub-module lsu_align (combinational) holds:
  - store-lane rotation and mask generation per beat;
  - load merge, shift and extension.
  It is parametrised by XLEN and shared with the future I-cache fill path.
- The top level holds only the FSM, the latches and the handshakes.

Test Plan:
- XLEN=32, load word at 0x100, signed, ready tied 1, rdata 0x8899AABB -> one beat at addr 0x100, mask 0xF; rsp_valid at T+2, rdata 0x8899AABB, rd echoed.
- Load byte at 0x103, signed, rdata 0x80112233 -> mask 0x8, rdata 0xFFFFFF80. Repeat unsigned -> 0x00000080.
- Load word at 0x102, split enabled; beat0 returns 0xDDCCBBAA, beat1 returns 0x44332211 -> beats at 0x100 (mask 0xC) and 0x104 (mask 0x3); rdata 0x2211DDCC; O_stall high for 3 cycles.
- Store half 0xBEEF at 0x203, ready low for 2 cycles per beat -> beat0 addr 0x200, mask 0x8, wdata[31:24] = 0xEF, held stable while ready is low; beat1 addr 0x204, mask 0x1, wdata[7:0] = 0xBE; rsp_valid with rdata 0.
- MISALIGN_SPLIT=0, load word at 0x101 -> no strobe; rsp_valid at T+1 with fault = 1. XLEN=32, size 3 -> same fault.
- Assert I_rst_n low while in BEAT1 with ready low -> strobes drop immediately, no rsp_valid; O_req_ready high on the first edge after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } lsu_state_t;

  function automatic logic [4:0] bytes_of(input logic [1:0] size);
    return 5'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_split_if.sv
// Request, response and data-memory signals of the load/store unit.
interface lsu_split_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              I_req_valid;
  logic              O_req_ready;
  logic              I_req_we;
  logic [1:0]        I_req_size;
  logic              I_req_signed;
  logic [ADDR_W-1:0] I_req_addr;
  logic [XLEN-1:0]   I_req_wdata;
  logic [4:0]        I_req_rd;
  logic              O_rsp_valid;
  logic [XLEN-1:0]   O_rsp_rdata;
  logic [4:0]        O_rsp_rd;
  logic              O_rsp_fault;
  logic [ADDR_W-1:0] O_dmem_addr;
  logic [XLEN-1:0]   O_dmem_wdata;
  logic [NB-1:0]     O_dmem_wmask;
  logic              O_dmem_rd;
  logic              O_dmem_we;
  logic              I_dmem_ready;
  logic [XLEN-1:0]   I_dmem_rdata;
  logic              O_stall;

  modport slave (
    input  I_req_valid, I_req_we, I_req_size, I_req_signed, I_req_addr,
           I_req_wdata, I_req_rd, I_dmem_ready, I_dmem_rdata,
    output O_req_ready, O_rsp_valid, O_rsp_rdata, O_rsp_rd, O_rsp_fault,
           O_dmem_addr, O_dmem_wdata, O_dmem_wmask, O_dmem_rd, O_dmem_we,
           O_stall
  );

  modport master (
    output I_req_valid, I_req_we, I_req_size, I_req_signed, I_req_addr,
           I_req_wdata, I_req_rd, I_dmem_ready, I_dmem_rdata,
    input  O_req_ready, O_rsp_valid, O_rsp_rdata, O_rsp_rd, O_rsp_fault,
           O_dmem_addr, O_dmem_wdata, O_dmem_wmask, O_dmem_rd, O_dmem_we,
           O_stall
  );

endinterface

// File: rtl/lsu_align.sv
// Lane alignment: store rotation and byte masks for both beats, load merge/shift/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  ld_lo,
  input  logic [XLEN-1:0]  ld_hi,
  output logic [XLEN-1:0]  st_wdata0,
  output logic [XLEN-1:0]  st_wdata1,
  output logic [NB-1:0]    wmask0,
  output logic [NB-1:0]    wmask1,
  output logic [XLEN-1:0]  ld_data
);
  logic [4:0]        nbytes;
  logic [2*NB-1:0]   mask_base;
  logic [2*NB-1:0]   mask_sh;
  logic [2*XLEN-1:0] st_sh;
  logic [2*XLEN-1:0] ld_sh;
  logic              sbit;

  assign nbytes = bytes_of(size);

  always_comb begin
    mask_base = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes)) mask_base[i] = 1'b1;
    end
  end

  // Double-width shifts: the upper half is whatever spills into the next bus word.
  assign mask_sh   = mask_base << off;
  assign wmask0    = mask_sh[NB-1:0];
  assign wmask1    = mask_sh[2*NB-1:NB];
  assign st_sh     = {{XLEN{1'b0}}, st_data} << {off, 3'b000};
  assign st_wdata0 = st_sh[XLEN-1:0];
  assign st_wdata1 = st_sh[2*XLEN-1:XLEN];
  assign ld_sh     = {ld_hi, ld_lo} >> {off, 3'b000};

  always_comb begin
    case (size)
      SZ_B:    sbit = ld_sh[7];
      SZ_H:    sbit = ld_sh[15];
      SZ_W:    sbit = ld_sh[31];
      default: sbit = ld_sh[XLEN-1];
    endcase
    ld_data = ld_sh[XLEN-1:0];
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8 * int'(nbytes)) ld_data[i] = sgn & sbit;
    end
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit: one request at a time; word-crossing accesses become two bus beats.
// state | meaning
// IDLE  | ready for a new request
// BEAT0 | first (or only) bus beat, held until dmem ready
// BEAT1 | second beat of a word-crossing access
// RESP  | one-cycle response pulse
module lsu_split
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input logic        I_clk,
  input logic        I_rst_n,
  lsu_split_if.slave bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t        state, state_nxt;
  logic              r_we, r_sgn, r_fault, r_cross;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_lo, r_hi;
  logic [4:0]        r_rd;

  logic [OFF_W-1:0]  req_off;
  logic              req_cross, req_fault;
  logic [ADDR_W-1:0] base_addr;
  logic [XLEN-1:0]   st_wdata0, st_wdata1, ld_data;
  logic [NB-1:0]     wmask0, wmask1;

  assign req_off   = bus.I_req_addr[OFF_W-1:0];
  assign req_cross = (6'(req_off) + 6'(bytes_of(bus.I_req_size))) > 6'(NB);
  assign req_fault = ((bus.I_req_size == SZ_D) && (XLEN != 64)) ||
                     (req_cross && (MISALIGN_SPLIT == 0));
  assign base_addr = r_addr & ~ADDR_W'(NB - 1);

  lsu_align #(.XLEN(XLEN)) u_align (
    .size      (r_size),
    .sgn       (r_sgn),
    .off       (r_addr[OFF_W-1:0]),
    .st_data   (r_wdata),
    .ld_lo     (r_lo),
    .ld_hi     (r_hi),
    .st_wdata0 (st_wdata0),
    .st_wdata1 (st_wdata1),
    .wmask0    (wmask0),
    .wmask1    (wmask1),
    .ld_data   (ld_data)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= ST_IDLE;
      r_we    <= 1'b0;
      r_sgn   <= 1'b0;
      r_fault <= 1'b0;
      r_cross <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.I_req_valid) begin
        r_we    <= bus.I_req_we;
        r_sgn   <= bus.I_req_signed;
        r_size  <= bus.I_req_size;
        r_addr  <= bus.I_req_addr;
        r_wdata <= bus.I_req_wdata;
        r_rd    <= bus.I_req_rd;
        r_fault <= req_fault;
        r_cross <= req_cross;
        r_lo    <= '0;
        r_hi    <= '0;
      end
      if (state == ST_BEAT0 && bus.I_dmem_ready) r_lo <= bus.I_dmem_rdata;
      if (state == ST_BEAT1 && bus.I_dmem_ready) r_hi <= bus.I_dmem_rdata;
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.O_req_ready  = (state == ST_IDLE) && I_rst_n;
    bus.O_stall      = (state != ST_IDLE);
    bus.O_dmem_addr  = '0;
    bus.O_dmem_wdata = '0;
    bus.O_dmem_wmask = '0;
    bus.O_dmem_rd    = 1'b0;
    bus.O_dmem_we    = 1'b0;
    bus.O_rsp_valid  = 1'b0;
    bus.O_rsp_rdata  = '0;
    bus.O_rsp_rd     = '0;
    bus.O_rsp_fault  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.I_req_valid) state_nxt = req_fault ? ST_RESP : ST_BEAT0;
      end
      ST_BEAT0: begin
        bus.O_dmem_addr  = base_addr;
        bus.O_dmem_wmask = wmask0;
        bus.O_dmem_wdata = r_we ? st_wdata0 : '0;
        bus.O_dmem_rd    = !r_we;
        bus.O_dmem_we    = r_we;
        if (bus.I_dmem_ready) state_nxt = r_cross ? ST_BEAT1 : ST_RESP;
      end
      ST_BEAT1: begin
        // Wraps to address 0 past the top bus word.
        bus.O_dmem_addr  = base_addr + ADDR_W'(NB);
        bus.O_dmem_wmask = wmask1;
        bus.O_dmem_wdata = r_we ? st_wdata1 : '0;
        bus.O_dmem_rd    = !r_we;
        bus.O_dmem_we    = r_we;
        if (bus.I_dmem_ready) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.O_rsp_valid = 1'b1;
        bus.O_rsp_fault = r_fault;
        if (!r_we) begin
          bus.O_rsp_rd = r_rd;
          if (!r_fault) bus.O_rsp_rdata = ld_data;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: byte-addressed memory model drives the bus and predicts every response.
module tb_lsu_split;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_split_if #(.XLEN(32), .ADDR_W(32)) ifa ();
  lsu_split_if #(.XLEN(32), .ADDR_W(32)) ifb ();

  lsu_split #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .bus(ifa)
  );
  lsu_split #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .bus(ifb)
  );

  int nchecks = 0;
  int nerr = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] obs_rdata;
  logic [4:0]  obs_rd;
  logic        obs_fault;
  int          nbeats;
  logic [31:0] beat_addr [2];
  logic [3:0]  beat_mask [2];
  logic [31:0] beat_wdata [2];

  function automatic logic [7:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Expected load value: gather bytes little-endian from memory, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic sgn);
    int n;
    logic [31:0] v;
    logic [7:0] top;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_get(addr + 32'(i));
    top = mem_get(addr + 32'(n - 1));
    if (sgn && top[7]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  // One request on the split-enabled unit; the bus waits wait_n cycles per beat.
  task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int wait_n);
    int n, exp_beats, cyc, waited, stall_cyc;
    bit done;
    logic [31:0] exp_val, exp_addr, held_addr, held_wdata;
    logic [3:0] exp_mask, held_mask;
    n = 1 << size;
    exp_beats = (int'(addr[1:0]) + n > 4) ? 2 : 1;
    exp_val = we ? 32'h0 : model_load(addr, size, sgn);
    nbeats = 0;
    held_addr = '0; held_wdata = '0; held_mask = '0;
    @(negedge clk);
    ifa.I_req_valid = 1'b1; ifa.I_req_we = we; ifa.I_req_size = size;
    ifa.I_req_signed = sgn; ifa.I_req_addr = addr; ifa.I_req_wdata = wdata; ifa.I_req_rd = rd;
    @(posedge clk); #1;
    ifa.I_req_valid = 1'b0; ifa.I_req_addr = $urandom; ifa.I_req_wdata = $urandom;
    ifa.I_req_rd = 5'($urandom); ifa.I_req_signed = ~sgn;
    cyc = 0; waited = 0; done = 0; stall_cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ifa.I_dmem_ready = 1'b0;
      ifa.I_dmem_rdata = $urandom;
      if (ifa.O_stall) stall_cyc++;
      if (ifa.O_dmem_rd || ifa.O_dmem_we) begin
        if (waited == 0) begin
          exp_addr = (addr & ~32'h3) + 32'(4 * nbeats);
          for (int j = 0; j < 4; j++) exp_mask[j] = ((exp_addr + 32'(j) - addr) < 32'(n));
          nchecks++;
          if ({ifa.O_dmem_rd, ifa.O_dmem_we} !== {!we, we}) begin
            nerr++; $display("FAIL strobe: rd/we=%b%b expected %b%b", ifa.O_dmem_rd, ifa.O_dmem_we, !we, we);
          end
          nchecks++;
          if (ifa.O_dmem_addr !== exp_addr) begin
            nerr++; $display("FAIL beat_addr: got %h expected %h", ifa.O_dmem_addr, exp_addr);
          end
          nchecks++;
          if (ifa.O_dmem_wmask !== exp_mask) begin
            nerr++; $display("FAIL beat_mask: got %h expected %h (addr %h)", ifa.O_dmem_wmask, exp_mask, addr);
          end
          held_addr = ifa.O_dmem_addr; held_mask = ifa.O_dmem_wmask; held_wdata = ifa.O_dmem_wdata;
        end else begin
          nchecks++;
          if (ifa.O_dmem_addr !== held_addr || ifa.O_dmem_wmask !== held_mask ||
              ifa.O_dmem_wdata !== held_wdata) begin
            nerr++; $display("FAIL hold: addr %h mask %h wdata %h changed from %h %h %h",
                             ifa.O_dmem_addr, ifa.O_dmem_wmask, ifa.O_dmem_wdata, held_addr, held_mask, held_wdata);
          end
        end
        if (waited < wait_n) begin
          waited++;
        end else begin
          ifa.I_dmem_ready = 1'b1;
          for (int j = 0; j < 4; j++) begin
            ifa.I_dmem_rdata[8*j +: 8] = mem_get(ifa.O_dmem_addr + 32'(j));
            if (ifa.O_dmem_we && ifa.O_dmem_wmask[j])
              mem[ifa.O_dmem_addr + 32'(j)] = ifa.O_dmem_wdata[8*j +: 8];
          end
          if (nbeats < 2) begin
            beat_addr[nbeats] = ifa.O_dmem_addr;
            beat_mask[nbeats] = ifa.O_dmem_wmask;
            beat_wdata[nbeats] = ifa.O_dmem_wdata;
          end
          nbeats++;
          waited = 0;
        end
      end else if (ifa.O_rsp_valid) begin
        done = 1;
        obs_rdata = ifa.O_rsp_rdata; obs_rd = ifa.O_rsp_rd; obs_fault = ifa.O_rsp_fault;
        nchecks++;
        if (nbeats != exp_beats) begin
          nerr++; $display("FAIL beats: got %0d expected %0d (addr %h)", nbeats, exp_beats, addr);
        end
        nchecks++;
        if (cyc != exp_beats * (wait_n + 1) + 1) begin
          nerr++; $display("FAIL latency: got %0d expected %0d", cyc, exp_beats * (wait_n + 1) + 1);
        end
        nchecks++;
        if (stall_cyc != cyc) begin
          nerr++; $display("FAIL stall: high %0d cycles expected %0d", stall_cyc, cyc);
        end
        nchecks++;
        if (obs_rdata !== exp_val || obs_fault !== 1'b0 || obs_rd !== (we ? 5'd0 : rd)) begin
          nerr++; $display("FAIL rsp: rdata %h rd %0d fault %b expected %h %0d 0 (addr %h size %0d)",
                           obs_rdata, obs_rd, obs_fault, exp_val, we ? 5'd0 : rd, addr, size);
        end
      end
    end
    nchecks++;
    if (!done) begin
      nerr++; $display("FAIL rsp_timeout: no response within 40 cycles (addr %h)", addr);
    end
    ifa.I_dmem_ready = 1'b0;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        nchecks++;
        if (mem_get(addr + 32'(i)) !== wdata[8*i +: 8]) begin
          nerr++; $display("FAIL store_byte: mem[%h]=%h expected %h", addr + 32'(i),
                           mem_get(addr + 32'(i)), wdata[8*i +: 8]);
        end
      end
    end
    @(negedge clk);
    nchecks++;
    if (ifa.O_rsp_valid !== 1'b0 || ifa.O_req_ready !== 1'b1) begin
      nerr++; $display("FAIL after_rsp: rsp_valid %b req_ready %b expected 0 1", ifa.O_rsp_valid, ifa.O_req_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    nchecks++;
    if ({ifa.O_dmem_rd, ifa.O_dmem_we, ifa.O_rsp_valid, ifa.O_stall, ifa.O_rsp_fault} !== 5'b0 ||
        ifa.O_dmem_addr !== 32'h0 || ifa.O_dmem_wmask !== 4'h0 || ifa.O_rsp_rdata !== 32'h0) begin
      nerr++; $display("FAIL reset_outputs: rd %b we %b rsp %b stall %b addr %h mask %h expected all 0",
                       ifa.O_dmem_rd, ifa.O_dmem_we, ifa.O_rsp_valid, ifa.O_stall, ifa.O_dmem_addr, ifa.O_dmem_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    nchecks++;
    if (ifa.O_req_ready !== 1'b1 || ifb.O_req_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready: got %b %b expected 1 1", ifa.O_req_ready, ifb.O_req_ready);
    end
  endtask

  task automatic test_load_word();
    set_word(32'h100, 32'h8899AABB);
    run_op(1'b0, SZ_W, 1'b1, 32'h100, 32'h0, 5'd17, 0);
    nchecks++;
    if (obs_rdata !== 32'h8899AABB || obs_rd !== 5'd17 || beat_addr[0] !== 32'h100 || beat_mask[0] !== 4'hF) begin
      nerr++; $display("FAIL load_word: rdata %h rd %0d addr %h mask %h expected 8899aabb 17 100 f",
                       obs_rdata, obs_rd, beat_addr[0], beat_mask[0]);
    end
  endtask

  task automatic test_load_byte();
    set_word(32'h100, 32'h80112233);
    run_op(1'b0, SZ_B, 1'b1, 32'h103, 32'h0, 5'd4, 0);
    nchecks++;
    if (obs_rdata !== 32'hFFFFFF80 || beat_mask[0] !== 4'h8) begin
      nerr++; $display("FAIL load_byte_s: rdata %h mask %h expected ffffff80 8", obs_rdata, beat_mask[0]);
    end
    run_op(1'b0, SZ_B, 1'b0, 32'h103, 32'h0, 5'd4, 1);
    nchecks++;
    if (obs_rdata !== 32'h00000080) begin
      nerr++; $display("FAIL load_byte_u: rdata %h expected 00000080", obs_rdata);
    end
  endtask

  task automatic test_split_load();
    set_word(32'h100, 32'hDDCCBBAA);
    set_word(32'h104, 32'h44332211);
    run_op(1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 5'd8, 0);
    nchecks++;
    if (obs_rdata !== 32'h2211DDCC || beat_addr[0] !== 32'h100 || beat_mask[0] !== 4'hC ||
        beat_addr[1] !== 32'h104 || beat_mask[1] !== 4'h3) begin
      nerr++; $display("FAIL split_load: rdata %h beats %h/%h %h/%h expected 2211ddcc 100/c 104/3",
                       obs_rdata, beat_addr[0], beat_mask[0], beat_addr[1], beat_mask[1]);
    end
  endtask

  task automatic test_store_half();
    run_op(1'b1, SZ_H, 1'b0, 32'h203, 32'h0000BEEF, 5'd9, 2);
    nchecks++;
    if (beat_addr[0] !== 32'h200 || beat_mask[0] !== 4'h8 || beat_wdata[0][31:24] !== 8'hEF ||
        beat_addr[1] !== 32'h204 || beat_mask[1] !== 4'h1 || beat_wdata[1][7:0] !== 8'hBE ||
        obs_rdata !== 32'h0) begin
      nerr++; $display("FAIL store_half: b0 %h/%h/%h b1 %h/%h/%h rdata %h", beat_addr[0], beat_mask[0],
                       beat_wdata[0], beat_addr[1], beat_mask[1], beat_wdata[1], obs_rdata);
    end
  endtask

  task automatic test_wrap();
    run_op(1'b0, SZ_W, 1'b0, 32'hFFFFFFFE, 32'h0, 5'd2, 0);
    nchecks++;
    if (beat_addr[0] !== 32'hFFFFFFFC || beat_addr[1] !== 32'h0) begin
      nerr++; $display("FAIL wrap: beats %h %h expected fffffffc 00000000", beat_addr[0], beat_addr[1]);
    end
  endtask

  task automatic test_nosplit();
    logic [1:0]  t_size [5] = '{SZ_W, SZ_H, SZ_B, SZ_H, SZ_B};
    logic        t_sgn  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_addr [5] = '{32'h101, 32'h103, 32'h103, 32'h102, 32'h103};
    logic        t_flt  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_exp  [5] = '{32'h0, 32'h0, 32'hFFFFFF80, 32'h00008011, 32'h00000080};
    int cyc;
    bit done, seen;
    ifb.I_dmem_rdata = 32'h80112233;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ifb.I_dmem_ready = 1'b1; ifb.I_req_valid = 1'b1; ifb.I_req_we = 1'b0;
      ifb.I_req_size = t_size[k]; ifb.I_req_signed = t_sgn[k]; ifb.I_req_addr = t_addr[k];
      ifb.I_req_rd = 5'd12;
      @(posedge clk); #1;
      ifb.I_req_valid = 1'b0;
      cyc = 0; done = 0; seen = 0;
      while (!done && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (ifb.O_dmem_rd || ifb.O_dmem_we) seen = 1;
        if (ifb.O_rsp_valid) begin
          done = 1;
          nchecks++;
          if (ifb.O_rsp_fault !== t_flt[k] || ifb.O_rsp_rdata !== t_exp[k] || cyc != (t_flt[k] ? 1 : 2)) begin
            nerr++; $display("FAIL nosplit_%0d: fault %b rdata %h at cycle %0d expected %b %h %0d", k,
                             ifb.O_rsp_fault, ifb.O_rsp_rdata, cyc, t_flt[k], t_exp[k], t_flt[k] ? 1 : 2);
          end
        end
      end
      nchecks++;
      if (!done || seen !== !t_flt[k]) begin
        nerr++; $display("FAIL nosplit_bus_%0d: done %b strobe_seen %b expected 1 %b", k, done, seen, !t_flt[k]);
      end
    end
    ifb.I_dmem_ready = 1'b0;
  endtask

  task automatic test_bad_size();
    @(negedge clk);
    ifa.I_req_valid = 1'b1; ifa.I_req_we = 1'b0; ifa.I_req_size = SZ_D;
    ifa.I_req_addr = 32'h100; ifa.I_req_rd = 5'd6;
    @(posedge clk); #1;
    ifa.I_req_valid = 1'b0;
    @(negedge clk);
    nchecks++;
    if (ifa.O_rsp_valid !== 1'b1 || ifa.O_rsp_fault !== 1'b1 || ifa.O_rsp_rdata !== 32'h0 ||
        ifa.O_dmem_rd !== 1'b0) begin
      nerr++; $display("FAIL bad_size: rsp %b fault %b rdata %h rd %b expected 1 1 0 0",
                       ifa.O_rsp_valid, ifa.O_rsp_fault, ifa.O_rsp_rdata, ifa.O_dmem_rd);
    end
    @(negedge clk);
    nchecks++;
    if (ifa.O_rsp_valid !== 1'b0 || ifa.O_req_ready !== 1'b1) begin
      nerr++; $display("FAIL bad_size_end: rsp %b ready %b expected 0 1", ifa.O_rsp_valid, ifa.O_req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc, rsp;
    acc = 0; rsp = 0;
    @(negedge clk);
    ifa.I_dmem_ready = 1'b1; ifa.I_dmem_rdata = 32'h12345678;
    ifa.I_req_valid = 1'b1; ifa.I_req_we = 1'b0; ifa.I_req_size = SZ_W;
    ifa.I_req_signed = 1'b0; ifa.I_req_addr = 32'h400; ifa.I_req_rd = 5'd3;
    for (int c = 0; c < 12; c++) begin
      if (ifa.O_req_ready) acc++;
      if (ifa.O_rsp_valid) begin
        rsp++;
        nchecks++;
        if (ifa.O_rsp_rdata !== 32'h12345678) begin
          nerr++; $display("FAIL b2b_rdata: got %h expected 12345678", ifa.O_rsp_rdata);
        end
      end
      @(negedge clk);
    end
    ifa.I_req_valid = 1'b0; ifa.I_dmem_ready = 1'b0;
    nchecks++;
    if (acc != 4 || rsp != 4) begin
      nerr++; $display("FAIL b2b_rate: accepts %0d responses %0d in 12 cycles expected 4 4", acc, rsp);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      addr = (i % 10 == 9) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                           : 32'h500 + 32'($urandom_range(0, 63));
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             addr, $urandom, 5'($urandom_range(1, 31)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ifa.I_req_valid = 1'b1; ifa.I_req_we = 1'b0; ifa.I_req_size = SZ_W;
    ifa.I_req_addr = 32'h306; ifa.I_req_rd = 5'd5;
    @(posedge clk); #1;
    ifa.I_req_valid = 1'b0;
    @(negedge clk);
    ifa.I_dmem_ready = 1'b1; ifa.I_dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    ifa.I_dmem_ready = 1'b0;
    nchecks++;
    if (ifa.O_dmem_rd !== 1'b1 || ifa.O_dmem_addr !== 32'h308) begin
      nerr++; $display("FAIL mid_beat1: rd %b addr %h expected 1 308", ifa.O_dmem_rd, ifa.O_dmem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    nchecks++;
    if (ifa.O_dmem_rd !== 1'b0 || ifa.O_dmem_we !== 1'b0 || ifa.O_stall !== 1'b0 || ifa.O_rsp_valid !== 1'b0) begin
      nerr++; $display("FAIL mid_reset_drop: rd %b we %b stall %b rsp %b expected 0 0 0 0",
                       ifa.O_dmem_rd, ifa.O_dmem_we, ifa.O_stall, ifa.O_rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    nchecks++;
    if (ifa.O_req_ready !== 1'b1) begin
      nerr++; $display("FAIL mid_reset_ready: got %b expected 1", ifa.O_req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nchecks++;
      if (ifa.O_rsp_valid !== 1'b0 || ifa.O_stall !== 1'b0) begin
        nerr++; $display("FAIL mid_reset_rsp: rsp %b stall %b expected 0 0", ifa.O_rsp_valid, ifa.O_stall);
      end
    end
  endtask

  initial begin
    ifa.I_req_valid = 1'b0; ifa.I_req_we = 1'b0; ifa.I_req_size = '0; ifa.I_req_signed = 1'b0;
    ifa.I_req_addr = '0; ifa.I_req_wdata = '0; ifa.I_req_rd = '0;
    ifa.I_dmem_ready = 1'b0; ifa.I_dmem_rdata = '0;
    ifb.I_req_valid = 1'b0; ifb.I_req_we = 1'b0; ifb.I_req_size = '0; ifb.I_req_signed = 1'b0;
    ifb.I_req_addr = '0; ifb.I_req_wdata = '0; ifb.I_req_rd = '0;
    ifb.I_dmem_ready = 1'b0; ifb.I_dmem_rdata = '0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_split_load();
    test_store_half();
    test_wrap();
    test_nosplit();
    test_bad_size();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
